// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 640x480@60 scan generator.
// Default geometry lives here; the top module can override it per instance.
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 16;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  sprite_addr_t;

    // Everything the colour stage sees, registered together so nothing skews.
    typedef struct packed {
        logic         hs_n;
        logic         vs_n;
        logic         blank_n;
        logic         frame_start;
        coord_t       x;
        coord_t       y;
        logic         is_logo;
        sprite_addr_t addr;
    } scan_out_t;

    localparam scan_out_t SCAN_RESET = '{
        hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, frame_start: 1'b0,
        x: '0, y: '0, is_logo: 1'b0, addr: '0
    };

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-generator output bundle plus the requested logo position.
// master = generator, slave = colour-mapping stage.
interface vga_scan_gen_if;
    import vga_timing_pkg::*;

    coord_t       logo_x;
    coord_t       logo_y;
    logic         pix_en;
    logic         VGA_HS;
    logic         VGA_VS;
    logic         blank_n;
    logic         frame_start;
    coord_t       DrawX;
    coord_t       DrawY;
    logic         is_logo;
    sprite_addr_t logo_address;

    modport master (
        input  logo_x, logo_y,
        output pix_en, VGA_HS, VGA_VS, blank_n, frame_start,
               DrawX, DrawY, is_logo, logo_address
    );

    modport slave (
        output logo_x, logo_y,
        input  pix_en, VGA_HS, VGA_VS, blank_n, frame_start,
               DrawX, DrawY, is_logo, logo_address
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: counts 0..TOTAL-1 on each step and exposes the decode of the
// value it will hold after this edge, so the parent can register that decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FP      = 16,
    parameter int SYNC    = 96,
    parameter int BP      = 48
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_step,
    output logic   o_wrap,
    output coord_t o_count_next,
    output logic   o_sync_n_next,
    output logic   o_visible_next
);

    localparam int     TOTAL      = VISIBLE + FP + SYNC + BP;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_START = coord_t'(VISIBLE + FP);
    localparam coord_t SYNC_END   = coord_t'(VISIBLE + FP + SYNC);
    localparam coord_t VIS_END    = coord_t'(VISIBLE);

    coord_t r_count;
    logic   w_last;

    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        w_last         = (r_count == LAST);
        o_wrap         = i_step && w_last;
        o_count_next   = r_count;
        if (i_step) begin
            o_count_next = w_last ? '0 : r_count + 1'b1;
        end
        o_sync_n_next  = !((o_count_next >= SYNC_START) && (o_count_next < SYNC_END));
        o_visible_next = (o_count_next < VIS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA pixel-timing and logo-window source: divider, H/V counters, and a single
// register stage holding sync, blank, coordinates and sprite address in lockstep.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CLK_DIV   = 2,
    parameter int LOGO_W    = 128,
    parameter int LOGO_H    = 64
) (
    input  logic           Clk,
    input  logic           Reset_n,
    vga_scan_gen_if.master bus
);

    localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_pix_en <= (r_div == DIV_LAST);
        end
    end

    logic   w_h_wrap, w_hs_n_next, w_h_vis_next;
    logic   w_v_wrap, w_vs_n_next, w_v_vis_next;
    coord_t w_hc_next, w_vc_next;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_axis (
        .clk            (Clk),
        .rst_n          (Reset_n),
        .i_step         (r_pix_en),
        .o_wrap         (w_h_wrap),
        .o_count_next   (w_hc_next),
        .o_sync_n_next  (w_hs_n_next),
        .o_visible_next (w_h_vis_next)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_axis (
        .clk            (Clk),
        .rst_n          (Reset_n),
        .i_step         (w_h_wrap),
        .o_wrap         (w_v_wrap),
        .o_count_next   (w_vc_next),
        .o_sync_n_next  (w_vs_n_next),
        .o_visible_next (w_v_vis_next)
    );

    // A vertical wrap is exactly the pixel-enable step onto (0,0).
    coord_t r_lx, r_ly;
    coord_t w_lx, w_ly;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lx <= '0;
            r_ly <= '0;
        end else if (w_v_wrap) begin
            r_lx <= bus.logo_x;
            r_ly <= bus.logo_y;
        end
    end

    // The frame's first pixel already uses the freshly sampled position, so a
    // whole frame is drawn against one window.
    assign w_lx = w_v_wrap ? bus.logo_x : r_lx;
    assign w_ly = w_v_wrap ? bus.logo_y : r_ly;

    logic [COORD_W:0] w_x_end, w_y_end;
    logic             w_inside, w_blank_n, w_is_logo;
    coord_t           w_dx, w_dy;
    scan_out_t        w_next, r_out;

    // 11-bit window ends keep a window hanging past 1023 from wrapping round.
    assign w_x_end   = {1'b0, w_lx} + (COORD_W+1)'(LOGO_W);
    assign w_y_end   = {1'b0, w_ly} + (COORD_W+1)'(LOGO_H);
    assign w_inside  = (w_hc_next >= w_lx) && ({1'b0, w_hc_next} < w_x_end) &&
                       (w_vc_next >= w_ly) && ({1'b0, w_vc_next} < w_y_end);
    assign w_blank_n = w_h_vis_next && w_v_vis_next;
    assign w_is_logo = w_inside && w_blank_n;
    assign w_dx      = w_hc_next - w_lx;
    assign w_dy      = w_vc_next - w_ly;

    always_comb begin
        w_next             = SCAN_RESET;
        w_next.hs_n        = w_hs_n_next;
        w_next.vs_n        = w_vs_n_next;
        w_next.blank_n     = w_blank_n;
        w_next.frame_start = w_v_wrap;
        w_next.x           = w_hc_next;
        w_next.y           = w_vc_next;
        w_next.is_logo     = w_is_logo;
        w_next.addr        = w_is_logo ? sprite_addr_t'(32'(w_dy) * LOGO_W + 32'(w_dx)) : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out <= SCAN_RESET;
        end else if (r_pix_en) begin
            r_out <= w_next;
        end
    end

    assign bus.pix_en       = r_pix_en;
    assign bus.VGA_HS       = r_out.hs_n;
    assign bus.VGA_VS       = r_out.vs_n;
    assign bus.blank_n      = r_out.blank_n;
    assign bus.frame_start  = r_out.frame_start;
    assign bus.DrawX        = r_out.x;
    assign bus.DrawY        = r_out.y;
    assign bus.is_logo      = r_out.is_logo;
    assign bus.logo_address = r_out.addr;

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Pixel-timing and sprite-address source for the VGA path.
- Generates 640x480@60 sync/blank, the current pixel coordinates DrawX/DrawY, and the logo-window decode (is_logo, logo_address).
- These outputs feed the colour-mapping stage directly.
- Runs on the 50 MHz system clock with an internal pixel-enable divider.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel (must be >= 1)
- LOGO_W, 128, logo sprite width (pixels)
- LOGO_H, 64, logo sprite height (pixels); LOGO_W*LOGO_H <= 65536

Ports:
- Clk input 1: system clock.
- Reset_n input 1: asynchronous, active-low reset.
- logo_x input 10: requested logo top-left X.
- logo_y input 10: requested logo top-left Y.
- pix_en output 1: one-Clk pulse per pixel period.
- VGA_HS output 1: horizontal sync, active low.
- VGA_VS output 1: vertical sync, active low.
- blank_n output 1: 1 = visible region.
- frame_start output 1: high for the pixel period at (0,0).
- DrawX output 10: current horizontal count.
- DrawY output 10: current vertical count.
- is_logo output 1: current pixel lies inside the visible logo window.
- logo_address output 16: sprite ROM address for the current pixel.

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async assert, sync release):
  - div=0, hc=0, vc=0, latched position=(0,0).
  - pix_en=0, VGA_HS=1, VGA_VS=1, blank_n=0, frame_start=0.
  - DrawX=0, DrawY=0, is_logo=0, logo_address=0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high in the cycle after div==CLK_DIV-1.
  - With CLK_DIV=1, pix_en is constantly 1 after reset.
- Counter advance, on each Clk edge where pix_en=1:
  - hc increments; at H_TOTAL-1 it wraps to 0.
  - When hc wraps, vc increments; at V_TOTAL-1 it wraps to 0.
- Output timing:
  - All outputs except pix_en are registered and load on the same edge as the counters, from the decoded next position (hc',vc').
  - Zero skew between sync, blank, coordinates and logo decode.
  - All outputs hold between pix_en edges.
- Decode for the next position (hc',vc'):
  - DrawX=hc', DrawY=vc'. Full range is output; values are not clamped during blanking.
  - blank_n = (hc' < H_VISIBLE) && (vc' < V_VISIBLE).
  - VGA_HS = 0 iff H_VISIBLE+H_FP <= hc' < H_VISIBLE+H_FP+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FP <= vc' < V_VISIBLE+V_FP+V_SYNC (490..491).
  - frame_start = (hc'==0 && vc'==0).
- Logo position latch:
  - logo_x/logo_y are sampled into lx/ly only on the edge that produces frame_start.
  - This makes the logo tear-free; mid-frame changes take effect next frame.
- Logo window decode:
  - Inside = lx <= hc' < lx+LOGO_W and ly <= vc' < ly+LOGO_H.
  - Compares use 11-bit sums, so a window extending past x=1023 or y=1023 does not wrap.
  - is_logo = inside && blank_n.
  - logo_address = (vc'-ly)*LOGO_W + (hc'-lx), truncated to 16 bits, when is_logo=1; else 0.
  - A window partially off the visible area shows only its visible part. No address is produced for blanked pixels.
- Reset asserted mid-frame: immediate return to the reset values. The scan restarts at (0,0); frame_start is asserted on the first pix_en edge after the scan wraps back to (0,0).
- No handshake: the downstream colour stage is purely combinational on these outputs.

Decomposition:
- Package vga_timing_pkg:
  - localparams for the 640x480 timing values and derived H_TOTAL/V_TOTAL.
  - Coordinate typedef coord_t (logic [9:0]).
  - Address typedef sprite_addr_t (logic [15:0]).
- One sub-module: vga_axis_counter, instantiated twice (horizontal and vertical).
  - Parameterised by VISIBLE, FP, SYNC, BP.
  - Inputs: step enable. Outputs: count, wrap, sync_n, visible.
  - Next-value outputs so the parent can register the decode.

Test Plan:
1. Reset_n=0 for 5 cycles, then release:
   - All outputs at reset values during reset.
   - First pix_en at Clk cycle 2 after release (CLK_DIV=2).
   - First pix_en edge gives DrawX=1, DrawY=0, blank_n=1.
2. Free-run 2 frames:
   - VGA_HS period is 1600 Clk, low for 192 Clk starting at DrawX=656.
   - VGA_VS period is 840000 Clk, low for lines 490-491.
   - frame_start pulses once per 840000 Clk.
3. logo_x=100, logo_y=50:
   - At (100,50): is_logo=1, logo_address=0.
   - At (227,113): logo_address=8191.
   - At (99,50) and (228,50): is_logo=0, logo_address=0.
4. logo_x=600, logo_y=450:
   - is_logo=1 at (639,479) with address 29*128+39=3751.
   - is_logo=0 at hc=640..727 on line 450 (blanked) and at vc>=480.
5. Change logo_x from 100 to 300 at line 200 mid-frame:
   - Window stays at X=100 for the rest of the frame.
   - Window moves to X=300 from the frame after the next frame_start.
6. Assert Reset_n at DrawX=400, DrawY=300:
   - Outputs return to reset values asynchronously, within the same Clk cycle.
   - After release, timing restarts from (0,0) with identical periods; the first frame_start occurs after one full 800x525 scan.
